// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV fp16 datapath blocks.
package spmv_pkg;

  localparam logic [15:0] FP16_ZERO     = 16'h0000;
  localparam int          ROW_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH
  } acc_state_t;

endpackage

// File: rtl/spmv_row_accum.sv
// Row-accumulation controller: steers fp16 products into an external registered adder
// and emits one row sum per row through a valid/ready output.
module spmv_row_accum
  import spmv_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEFAULT,
  parameter int N_ROWS = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_prod_valid,
  output logic             o_prod_ready,
  input  logic [15:0]      i_prod_data,
  input  logic             i_prod_last,
  input  logic [ROW_W-1:0] i_prod_row,
  output logic [15:0]      o_add_a,
  output logic [15:0]      o_add_b,
  input  logic [15:0]      i_add_result,
  output logic             o_sum_valid,
  input  logic             i_sum_ready,
  output logic [15:0]      o_sum_data,
  output logic [ROW_W-1:0] o_sum_row,
  output logic             o_frame_done,
  output logic             o_busy
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

  acc_state_t       state_reg;
  logic             first_reg;
  logic [ROW_W-1:0] pend_row_reg;
  logic [ROW_W-1:0] row_cnt_reg;
  logic             beat;
  logic             sum_accept;

  // A beat is refused during FLUSH and while a held sum blocks the output.
  assign o_prod_ready = (state_reg != FLUSH) && (!o_sum_valid || i_sum_ready);
  assign beat         = i_prod_valid && o_prod_ready;
  assign sum_accept   = o_sum_valid && i_sum_ready;
  assign o_busy       = (state_reg != IDLE) || o_sum_valid;

  // Without a beat the adder sees result + 0, so its register holds the partial sum.
  always_comb begin
    o_add_a = FP16_ZERO;
    o_add_b = i_add_result;
    if (beat) begin
      o_add_a = i_prod_data;
      if (first_reg) begin
        o_add_b = FP16_ZERO;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg    <= IDLE;
      first_reg    <= 1'b1;
      pend_row_reg <= '0;
      row_cnt_reg  <= '0;
      o_sum_valid  <= 1'b0;
      o_sum_data   <= FP16_ZERO;
      o_sum_row    <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (sum_accept) begin
        o_sum_valid <= 1'b0;
        if (row_cnt_reg == LAST_ROW) begin
          row_cnt_reg  <= '0;
          o_frame_done <= 1'b1;
        end else begin
          row_cnt_reg <= row_cnt_reg + 1'b1;
        end
      end

      case (state_reg)
        IDLE, ACCUM: begin
          if (beat) begin
            first_reg <= 1'b0;
            if (i_prod_last) begin
              state_reg    <= FLUSH;
              pend_row_reg <= i_prod_row;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        // The adder register now holds the complete row sum; a capture here
        // overrides a same-cycle accept so valid stays high.
        FLUSH: begin
          o_sum_data  <= i_add_result;
          o_sum_row   <= pend_row_reg;
          o_sum_valid <= 1'b1;
          first_reg   <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_row_accum.sv
// Randomised and directed bench for spmv_row_accum with a behavioural registered fp16 adder
// and a queue-based row-sum reference.
module tb_spmv_row_accum;

  typedef struct packed {
    logic [3:0]  row;
    logic [15:0] data;
  } sum_t;

  logic        clk;
  logic        rstn;
  logic        i_prod_valid;
  logic        o_prod_ready;
  logic [15:0] i_prod_data;
  logic        i_prod_last;
  logic [3:0]  i_prod_row;
  logic [15:0] o_add_a;
  logic [15:0] o_add_b;
  logic [15:0] add_result;
  logic        o_sum_valid;
  logic        i_sum_ready;
  logic [15:0] o_sum_data;
  logic [3:0]  o_sum_row;
  logic        o_frame_done;
  logic        o_busy;

  int   checks = 0;
  int   errors = 0;
  sum_t exp_q[$];
  real  acc_r = 0.0;
  int   acc_cnt = 0;
  bit   prev16 = 0;
  int   frame_pulses = 0;
  bit   rand_ready = 0;
  int   rows_sent = 0;
  int   sums_seen = 0;
  logic [15:0] last_sum_data = '0;
  logic [3:0]  last_sum_row = '0;

  spmv_row_accum #(.ROW_W(4), .N_ROWS(16)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_prod_valid (i_prod_valid),
    .o_prod_ready (o_prod_ready),
    .i_prod_data  (i_prod_data),
    .i_prod_last  (i_prod_last),
    .i_prod_row   (i_prod_row),
    .o_add_a      (o_add_a),
    .o_add_b      (o_add_b),
    .i_add_result (add_result),
    .o_sum_valid  (o_sum_valid),
    .i_sum_ready  (i_sum_ready),
    .o_sum_data   (o_sum_data),
    .o_sum_row    (o_sum_row),
    .o_frame_done (o_frame_done),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  a;
    int   e;
    int   m;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    return {s, 5'(e), 10'(m)};
  endfunction

  // Stand-in for the external adder: result registered one cycle after its operands.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) add_result <= 16'h0000;
    else       add_result <= r2h(h2r(o_add_a) + h2r(o_add_b));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, update the reference, score any accepted sum.
  task automatic tick(output bit took);
    sum_t e;
    @(negedge clk);
    took = i_prod_valid && o_prod_ready;
    if (o_frame_done || prev16) check("frame_done", o_frame_done, prev16);
    prev16 = 0;
    if (o_sum_valid && i_sum_ready) begin
      check("sum_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sum_data", o_sum_data, e.data);
        check("sum_row", o_sum_row, e.row);
      end
      $display("sum row=%0d data=%h", o_sum_row, o_sum_data);
      last_sum_data = o_sum_data;
      last_sum_row  = o_sum_row;
      sums_seen++;
      acc_cnt++;
      prev16 = (acc_cnt % 16 == 0);
    end
    if (o_frame_done) frame_pulses++;
    if (took) begin
      acc_r += h2r(i_prod_data);
      if (i_prod_last) begin
        exp_q.push_back('{row: i_prod_row, data: r2h(acc_r)});
        acc_r = 0.0;
        rows_sent++;
      end
    end
    @(posedge clk);
    #1;
    if (rand_ready) i_sum_ready = ($urandom_range(3) != 0);
  endtask

  task automatic idle(input int n);
    bit t;
    for (int k = 0; k < n; k++) tick(t);
  endtask

  task automatic send(input logic [15:0] d, input logic l, input logic [3:0] r);
    bit took;
    took = 0;
    i_prod_valid = 1'b1;
    i_prod_data  = d;
    i_prod_last  = l;
    i_prod_row   = r;
    for (int n = 0; n < 64 && !took; n++) tick(took);
    check("beat_accepted", took, 1);
    i_prod_valid = 1'b0;
    i_prod_last  = 1'b0;
  endtask

  task automatic drain();
    i_sum_ready = 1'b1;
    for (int n = 0; n < 64 && (exp_q.size() != 0 || o_busy); n++) idle(1);
    idle(2);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    i_prod_valid = 1'b0;
    i_prod_last  = 1'b0;
    i_prod_data  = '0;
    i_prod_row   = '0;
    #1;
    check("rst_sum_valid", o_sum_valid, 0);
    check("rst_sum_data", o_sum_data, 0);
    check("rst_sum_row", o_sum_row, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_add_a", o_add_a, 0);
    check("rst_add_b", o_add_b, 0);
    exp_q.delete();
    acc_r = 0.0;
    acc_cnt = 0;
    prev16 = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int   len;
    int   v;
    logic [15:0] d;
    logic [3:0]  r;
    rstn = 1'b1;
    i_prod_valid = 1'b0;
    i_prod_data = '0;
    i_prod_last = 1'b0;
    i_prod_row = '0;
    i_sum_ready = 1'b0;
    apply_reset();
    #1 check("idle_ready", o_prod_ready, 1);

    // 1) two-beat row, latency t_last+2
    i_sum_ready = 1'b0;
    send(16'h3C00, 1'b0, 4'd2);
    send(16'h4000, 1'b1, 4'd2);
    check("lat_t1_valid", o_sum_valid, 0);
    check("flush_ready", o_prod_ready, 0);
    check("flush_busy", o_busy, 1);
    idle(1);
    check("lat_t2_valid", o_sum_valid, 1);
    check("t1_data", o_sum_data, 16'h4200);
    check("t1_row", o_sum_row, 2);
    i_sum_ready = 1'b1;
    idle(1);
    check("t1_cleared", o_sum_valid, 0);

    // 2) single-beat row, mixed signs, zero-exponent row
    send(16'h3800, 1'b1, 4'd5);
    drain();
    check("t2a_data", last_sum_data, 16'h3800);
    check("t2a_row", last_sum_row, 5);
    send(16'h4200, 1'b0, 4'd6);
    send(16'hBC00, 1'b1, 4'd6);
    drain();
    check("t2b_data", last_sum_data, 16'h4000);
    send(16'h0155, 1'b0, 4'd8);
    send(16'h8200, 1'b1, 4'd8);
    drain();
    check("t2c_zero", last_sum_data, 16'h0000);

    // 3) held sum backpressures the product stream
    i_sum_ready = 1'b0;
    send(16'h3C00, 1'b0, 4'd3);
    send(16'h3C00, 1'b1, 4'd3);
    idle(1);
    i_prod_valid = 1'b1;
    i_prod_data  = 16'h4400;
    i_prod_row   = 4'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready", o_prod_ready, 0);
      check("hold_valid", o_sum_valid, 1);
      check("hold_data", o_sum_data, 16'h4000);
      check("hold_add_a", o_add_a, 16'h0000);
      check("hold_add_b", o_add_b, 16'h4000);
      idle(1);
    end
    i_sum_ready = 1'b1;
    send(16'h4400, 1'b0, 4'd4);
    check("t3_prior", last_sum_data, 16'h4000);
    send(16'h3C00, 1'b1, 4'd4);
    drain();
    check("t3_data", last_sum_data, 16'h4500);
    check("t3_row", last_sum_row, 4);

    // 4) gaps mid-row hold the accumulator
    send(16'h3C00, 1'b0, 4'd7);
    idle(3);
    send(16'h3C00, 1'b1, 4'd7);
    drain();
    check("t4_data", last_sum_data, 16'h4000);

    // 5) reset mid-row discards the partial sum
    send(16'h3C00, 1'b0, 4'd9);
    apply_reset();
    send(16'h3800, 1'b1, 4'd9);
    drain();
    check("t5_data", last_sum_data, 16'h3800);
    check("t5_row", last_sum_row, 9);

    // 6) frame of 16 rows, then a second frame
    apply_reset();
    frame_pulses = 0;
    for (int i = 0; i < 15; i++) send(r2h(real'(i + 1)), 1'b1, 4'(i));
    drain();
    check("frame_early", frame_pulses, 0);
    send(16'h3C00, 1'b1, 4'd15);
    drain();
    check("frame_once", frame_pulses, 1);
    for (int i = 0; i < 16; i++) send(r2h(real'(16 - i)), 1'b1, 4'(i));
    drain();
    check("frame_wrap", frame_pulses, 2);

    // 7) random rows, random gaps and random consumer stalls
    rows_sent = 0;
    sums_seen = 0;
    rand_ready = 1;
    for (int row_i = 0; row_i < 40; row_i++) begin
      len = int'($urandom_range(1, 5));
      r = 4'($urandom_range(15));
      for (int b = 0; b < len; b++) begin
        v = int'($urandom_range(17));
        if (v == 17) d = 16'h0155;
        else         d = r2h(real'(v - 8) * 0.25);
        send(d, (b == len - 1), r);
        idle(int'($urandom_range(2)));
      end
    end
    rand_ready = 0;
    drain();
    check("rand_rows", sums_seen, rows_sent);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
